// File: rtl/seq_mult_core_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and state width.
package seq_mult_core_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mult_core_ctrl.sv
// Multiplier controller: state machine plus iteration counter, emitting
// load/iter/fix strobes to the datapath and registered busy/done.
module seq_mult_core_ctrl
  import seq_mult_core_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   mplier_rest_zero,
  output logic   load,
  output logic   iter,
  output logic   fix,
  output logic   busy,
  output logic   done,
  output state_t state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;
  logic          stop_early;

  assign load = start && (state == IDLE || state == DONE);
  assign iter = (state == ITER);
  assign fix  = (state == FIX);

  // mplier_rest_zero reflects the multiplier after this cycle's shift
  assign stop_early = (EARLY_TERM != 0) && mplier_rest_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ITER;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ITER: begin
          count <= count + 1'b1;
          if (count == LAST || stop_early) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// Sequential WIDTH x WIDTH multiplier with signed/unsigned operands,
// optional early termination and a start/busy/done handshake.
module seq_mult_core
  import seq_mult_core_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [STATE_W-1:0]   state_out
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               load;
  logic               iter;
  logic               fix;
  state_t             state;

  // Most-negative operand negates to itself, which is the exact magnitude unsigned
  assign mag_a = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;

  assign state_out = state;

  seq_mult_core_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_TERM (EARLY_TERM)
  ) u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .mplier_rest_zero (mplier[WIDTH-1:1] == '0),
    .load             (load),
    .iter             (iter),
    .fix              (fix),
    .busy             (busy),
    .done             (done),
    .state            (state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, mag_a};
      mplier  <= mag_b;
      neg     <= signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (iter) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (fix) begin
      product <= neg ? -acc : acc;
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Scoreboard bench for seq_mult_core: one instance with early termination,
// one without, driven from the same inputs and checked independently.
module tb_seq_mult_core;

  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    int             n;
    int             done_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy_et, busy_full;
  logic           done_et, done_full;
  logic [2*W-1:0] product_et, product_full;
  logic [1:0]     state_et, state_full;

  exp_t q_et[$];
  exp_t q_full[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   run_et = 0, run_full = 0;
  logic prev_done_et = 1'b0, prev_done_full = 1'b0;

  seq_mult_core #(.WIDTH(W), .EARLY_TERM(1)) u_dut_et (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy_et),
    .done        (done_et),
    .product     (product_et),
    .state_out   (state_et)
  );

  seq_mult_core #(.WIDTH(W), .EARLY_TERM(0)) u_dut_full (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy_full),
    .done        (done_full),
    .product     (product_full),
    .state_out   (state_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: full-width signed or unsigned product and early-exit count
  function automatic logic [2*W-1:0] model_product(input vec_t v);
    int sa, sb;
    int prod;
    sa = v.sgn ? int'($signed(v.a)) : int'(v.a);
    sb = v.sgn ? int'($signed(v.b)) : int'(v.b);
    prod = sa * sb;
    return prod[2*W-1:0];
  endfunction

  function automatic int model_iters_et(input vec_t v);
    int mb;
    int n;
    mb = (v.sgn && v.b[W-1]) ? ((1 << W) - int'(v.b)) : int'(v.b);
    n = 1;
    for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
    return n;
  endfunction

  task automatic push_expected(input vec_t v);
    exp_t e;
    e.prod     = model_product(v);
    e.n        = model_iters_et(v);
    e.done_cyc = cyc + e.n + 2;
    q_et.push_back(e);
    e.n        = W;
    e.done_cyc = cyc + W + 2;
    q_full.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done_et) begin
      check_value("et_done_width", 32'(prev_done_et), 32'd0);
      if (q_et.size() == 0) begin
        check_value("et_spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_et.pop_front();
        check_value("et_product", 32'(product_et), 32'(e.prod));
        check_value("et_latency", 32'(cyc), 32'(e.done_cyc));
        check_value("et_busy_len", 32'(run_et), 32'(e.n + 1));
      end
      run_et = 0;
    end else if (busy_et) begin
      run_et++;
    end else begin
      run_et = 0;
    end
    prev_done_et = done_et;
  end

  always @(negedge clk) begin
    if (done_full) begin
      check_value("full_done_width", 32'(prev_done_full), 32'd0);
      if (q_full.size() == 0) begin
        check_value("full_spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_full.pop_front();
        check_value("full_product", 32'(product_full), 32'(e.prod));
        check_value("full_latency", 32'(cyc), 32'(e.done_cyc));
        check_value("full_busy_len", 32'(run_full), 32'(e.n + 1));
      end
      run_full = 0;
    end else if (busy_full) begin
      run_full++;
    end else begin
      run_full = 0;
    end
    prev_done_full = done_full;
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q_et.size() == 0 && q_full.size() == 0 &&
          state_et == 2'd0 && state_full == 2'd0) return;
    end
    check_value("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v, input int mid_iter_start);
    @(negedge clk);
    op_a = v.a; op_b = v.b; signed_mode = v.sgn; start = 1'b1;
    push_expected(v);
    @(negedge clk);
    start = 1'b0;
    op_a = '0; op_b = '0; signed_mode = 1'b0;
    if (mid_iter_start != 0) begin
      @(negedge clk);
      start = 1'b1; op_a = 4'hF; op_b = 4'hF;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_et_state"},   32'(state_et),     32'd0);
    check_value({tag, "_et_busy"},    32'(busy_et),      32'd0);
    check_value({tag, "_et_done"},    32'(done_et),      32'd0);
    check_value({tag, "_et_prod"},    32'(product_et),   32'd0);
    check_value({tag, "_full_state"}, 32'(state_full),   32'd0);
    check_value({tag, "_full_busy"},  32'(busy_full),    32'd0);
    check_value({tag, "_full_done"},  32'(done_full),    32'd0);
    check_value({tag, "_full_prod"},  32'(product_full), 32'd0);
  endtask

  vec_t vecs[10] = '{
    '{4'hA, 4'hA, 1'b0}, '{4'hF, 4'hF, 1'b0}, '{4'h0, 4'h9, 1'b0},
    '{4'h9, 4'h0, 1'b0}, '{4'h3, 4'h5, 1'b0}, '{4'hD, 4'h5, 1'b1},
    '{4'h8, 4'h8, 1'b1}, '{4'h8, 4'h7, 1'b1}, '{4'hF, 4'hF, 1'b1},
    '{4'h6, 4'h9, 1'b1}
  };

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    foreach (vecs[i]) apply_stimulus(vecs[i], 0);

    // start pulsed during ITER must not disturb the running multiply
    v = '{4'h7, 4'h9, 1'b0};
    apply_stimulus(v, 1);

    // start held through DONE: second multiply launches without an IDLE cycle
    begin
      vec_t v2;
      v  = '{4'hB, 4'hD, 1'b0};
      v2 = '{4'h5, 4'h9, 1'b0};
      @(negedge clk);
      op_a = v.a; op_b = v.b; signed_mode = v.sgn; start = 1'b1;
      push_expected(v);
      for (int i = 0; i < 20 && !done_full; i++) @(negedge clk);
      check_value("b2b_first_done", 32'(done_full), 32'd1);
      op_a = v2.a; op_b = v2.b; signed_mode = v2.sgn;
      push_expected(v2);
      @(negedge clk);
      start = 1'b0;
      check_value("b2b_no_idle", 32'(state_full), 32'd1);
      wait_idle();
    end

    // reset in the second ITER cycle abandons the operation
    v = '{4'hB, 4'hD, 1'b0};
    @(negedge clk);
    op_a = v.a; op_b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midreset");

    v = '{4'h6, 4'h7, 1'b0};
    apply_stimulus(v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
